// File: rtl/led_pwm_pkg.sv
// -----------------------------------------------------------------------------
// led_pwm_pkg
//   Shared definitions for the LED PWM output stage: register word offsets,
//   CTRL bit positions, the duty reset value and the blink period width.
// -----------------------------------------------------------------------------
package led_pwm_pkg;

    typedef enum logic [1:0] {
        REG_CTRL   = 2'd0,
        REG_BLINK  = 2'd1,
        REG_STATUS = 2'd2,
        REG_RSVD   = 2'd3
    } reg_addr_e;

    localparam int unsigned EN_BIT       = 8;
    localparam int unsigned BLINK_EN_BIT = 9;

    // All ones; sliced down to PWM_BITS where used.
    localparam logic [31:0] DUTY_RESET = 32'hFFFF_FFFF;

    localparam int unsigned BLINK_W = 24;

endpackage

// File: rtl/led_pwm_timebase.sv
// -----------------------------------------------------------------------------
// led_pwm_timebase
//   Prescaler plus free-running PWM counter.
//   Ports:
//     clk, reset  : clock, asynchronous active-high reset
//     tick        : prescaler at PRESCALE-1 (one PWM counter step this cycle)
//     period_end  : tick on the last PWM count (pwm_cnt all ones)
//     pwm_cnt     : current PWM counter value
// -----------------------------------------------------------------------------
module led_pwm_timebase #(
    parameter int unsigned PRESCALE = 16,
    parameter int unsigned PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                reset,
    output logic                tick,
    output logic                period_end,
    output logic [PWM_BITS-1:0] pwm_cnt
);

    localparam int unsigned     PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] presc;

    assign tick       = (presc == PS_LAST);
    assign period_end = tick && (pwm_cnt == '1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc   <= '0;
            pwm_cnt <= '0;
        end else if (tick) begin
            presc   <= '0;
            pwm_cnt <= pwm_cnt + 1'b1;
        end else begin
            presc   <= presc + 1'b1;
        end
    end

endmodule

// File: rtl/led_pwm_stage.sv
// -----------------------------------------------------------------------------
// led_pwm_stage
//   LED pin output stage: global PWM brightness and optional blink applied on
//   top of the pattern from the LED register device. MMIO slave with CTRL,
//   BLINK and STATUS word registers. With en=0 it is a registered pass-through.
//   Ports:
//     clk, reset : clock, asynchronous active-high reset
//     WE         : write enable for this device
//     Addr       : word offset (0=CTRL, 1=BLINK, 2=STATUS, 3=reserved)
//     Din        : write data
//     Dout       : read data, combinational on Addr
//     led_in     : LED pattern in pin polarity
//     led_out    : registered LED pins
//   Build option: define LED_PWM_GAMMA_EN to compare the PWM counter against
//   (duty_act*duty_act)>>PWM_BITS instead of duty_act.
// -----------------------------------------------------------------------------
module led_pwm_stage
    import led_pwm_pkg::*;
#(
    parameter int unsigned PRESCALE   = 16,
    parameter int unsigned PWM_BITS   = 8,
    parameter int unsigned ACTIVE_LOW = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        WE,
    input  logic [1:0]  Addr,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    input  logic [31:0] led_in,
    output logic [31:0] led_out
);

    localparam logic [31:0]         OFF       = (ACTIVE_LOW != 0) ? 32'hFFFF_FFFF : 32'h0;
    localparam logic [PWM_BITS-1:0] DUTY_INIT = DUTY_RESET[PWM_BITS-1:0];

    logic [PWM_BITS-1:0] duty_req;
    logic [PWM_BITS-1:0] duty_act;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] cmp_val;
    logic                en;
    logic                blink_en;
    logic                blink_state;
    logic [BLINK_W-1:0]  blink_period;
    logic [BLINK_W-1:0]  blink_cnt;
    logic                period_end;
    logic                pwm_on;
    logic                gate;
    logic                wr_ctrl;
    logic                wr_blink;

    // Only period_end is needed here; the per-step tick is left unused.
    logic                tick_unused;
    logic                unused_din;
    assign unused_din = ^Din[31:BLINK_W];

    led_pwm_timebase #(
        .PRESCALE (PRESCALE),
        .PWM_BITS (PWM_BITS)
    ) u_timebase (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick_unused),
        .period_end (period_end),
        .pwm_cnt    (pwm_cnt)
    );

`ifdef LED_PWM_GAMMA_EN
    assign cmp_val = PWM_BITS'(((2*PWM_BITS)'(duty_act) * (2*PWM_BITS)'(duty_act)) >> PWM_BITS);
`else
    assign cmp_val = duty_act;
`endif

    // The 0 and full-scale cases are decided on the raw duty so that full
    // brightness stays solid on and zero stays solid off.
    always_comb begin
        pwm_on = 1'b0;
        if (duty_act == '0)
            pwm_on = 1'b0;
        else if (duty_act == '1)
            pwm_on = 1'b1;
        else
            pwm_on = (pwm_cnt < cmp_val);
    end

    assign gate     = pwm_on && (!blink_en || blink_state);
    assign wr_ctrl  = WE && (Addr == REG_CTRL);
    assign wr_blink = WE && (Addr == REG_BLINK);

    always_comb begin
        Dout = '0;
        case (reg_addr_e'(Addr))
            REG_CTRL: begin
                Dout[PWM_BITS-1:0]  = duty_req;
                Dout[EN_BIT]        = en;
                Dout[BLINK_EN_BIT]  = blink_en;
            end
            REG_BLINK:  Dout[BLINK_W-1:0] = blink_period;
            REG_STATUS: begin
                Dout[0]             = pwm_on;
                Dout[1]             = blink_state;
                Dout[8 +: PWM_BITS] = duty_act;
            end
            default:    Dout = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            duty_req     <= DUTY_INIT;
            duty_act     <= DUTY_INIT;
            en           <= 1'b0;
            blink_en     <= 1'b0;
            blink_period <= '0;
            blink_cnt    <= '0;
            blink_state  <= 1'b1;
            led_out      <= OFF;
        end else begin
            if (wr_ctrl) begin
                duty_req <= Din[PWM_BITS-1:0];
                en       <= Din[EN_BIT];
                blink_en <= Din[BLINK_EN_BIT];
            end

            // Shadow load picks up the pre-write duty_req if a CTRL write
            // coincides with period_end.
            if (period_end)
                duty_act <= duty_req;

            if (wr_blink) begin
                blink_period <= Din[BLINK_W-1:0];
                blink_cnt    <= '0;
                blink_state  <= 1'b1;
            end else if (period_end) begin
                if (blink_period == '0) begin
                    blink_state <= 1'b1;
                end else if (blink_cnt == blink_period - 1'b1) begin
                    blink_state <= ~blink_state;
                    blink_cnt   <= '0;
                end else begin
                    blink_cnt   <= blink_cnt + 1'b1;
                end
            end

            led_out <= (!en || gate) ? led_in : OFF;
        end
    end

endmodule

// File: tb/tb_led_pwm_stage.sv
// -----------------------------------------------------------------------------
// tb_led_pwm_stage
//   Directed bench for led_pwm_stage with PRESCALE=2, PWM_BITS=8, ACTIVE_LOW=1.
//   cyc counts rising edges since the last reset release; led_out seen after
//   edge m reflects the PWM/blink state left by edge m-1.
// -----------------------------------------------------------------------------
module tb_led_pwm_stage;
    import led_pwm_pkg::*;

    localparam logic [31:0] OFF = 32'hFFFF_FFFF;
    localparam logic [31:0] PAT = 32'h5A5A_0F0F;
`ifdef LED_PWM_GAMMA_EN
    // (0x80*0x80)>>8 = 0x40 -> 64 on-steps
    localparam logic [31:0] DUTY_A = 32'h0000_0080;
`else
    localparam logic [31:0] DUTY_A = 32'h0000_0040;
`endif

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        WE;
    logic [1:0]  Addr;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic [31:0] led_in;
    logic [31:0] led_out;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    led_pwm_stage #(
        .PRESCALE   (2),
        .PWM_BITS   (8),
        .ACTIVE_LOW (1)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .WE      (WE),
        .Addr    (Addr),
        .Din     (Din),
        .Dout    (Dout),
        .led_in  (led_in),
        .led_out (led_out)
    );

    typedef struct {
        logic [1:0]  addr;
        logic [31:0] exp;
    } rd_vec_t;

    typedef struct {
        logic [31:0] led_in;
        logic [31:0] exp_out;
    } pt_vec_t;

    typedef struct {
        logic [1:0]  wr_addr;
        logic [31:0] wr_data;
        logic [1:0]  rd_addr;
        logic [31:0] exp;
    } reg_vec_t;

    rd_vec_t  rd_tab [4];
    pt_vec_t  pt_tab [5];
    reg_vec_t reg_tab[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h want=%08h cyc=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic wait_until(input int m);
        int guard;
        guard = 0;
        while (cyc < m && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != m) begin
            bad++;
            $display("FAIL sync: got cyc=%0d want=%0d", cyc, m);
        end
    endtask

    task automatic check_win(input string name, input int a, input int b, input logic [31:0] exp);
        wait_until(a);
        for (int m = a; m <= b; m++) begin
            chk(name, led_out, exp);
            @(negedge clk);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        WE   = 1'b1;
        Addr = a;
        Din  = d;
        @(negedge clk);
        WE   = 1'b0;
        Din  = '0;
    endtask

    task automatic bus_read(input string name, input logic [1:0] a, input logic [31:0] exp);
        Addr = a;
        #1;
        chk(name, Dout, exp);
    endtask

    initial begin
        logic [31:0] prev;

        rd_tab[0] = '{REG_CTRL,   32'h0000_00FF};
        rd_tab[1] = '{REG_BLINK,  32'h0000_0000};
        rd_tab[2] = '{REG_STATUS, 32'h0000_FF03};
        rd_tab[3] = '{REG_RSVD,   32'h0000_0000};

        pt_tab[0] = '{32'h0000_FFF0, 32'h0000_FFF0};
        pt_tab[1] = '{32'h1234_5678, 32'h1234_5678};
        pt_tab[2] = '{32'h0000_0000, 32'h0000_0000};
        pt_tab[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF};
        pt_tab[4] = '{32'hA5A5_A5A5, 32'hA5A5_A5A5};

        reg_tab[0] = '{REG_CTRL,   32'hFFFF_FF12, REG_CTRL,   32'h0000_0312};
        reg_tab[1] = '{REG_CTRL,   32'h0000_0000, REG_CTRL,   32'h0000_0000};
        reg_tab[2] = '{REG_BLINK,  32'hABCD_EF12, REG_BLINK,  32'h00CD_EF12};
        reg_tab[3] = '{REG_BLINK,  32'h0000_0000, REG_BLINK,  32'h0000_0000};
        reg_tab[4] = '{REG_STATUS, 32'h1234_5678, REG_STATUS, 32'h0000_FF03};
        reg_tab[5] = '{REG_RSVD,   32'hFFFF_FFFF, REG_RSVD,   32'h0000_0000};
        reg_tab[6] = '{REG_RSVD,   32'hFFFF_FFFF, REG_CTRL,   32'h0000_0000};
        reg_tab[7] = '{REG_STATUS, 32'hFFFF_FFFF, REG_BLINK,  32'h0000_0000};

        WE = 1'b0; Addr = '0; Din = '0; led_in = '0;

        // Reset state
        #1 reset = 1'b1;
        #1 chk("rst_led", led_out, OFF);
        for (int i = 0; i < 4; i++)
            bus_read($sformatf("rst_rd%0d", i), rd_tab[i].addr, rd_tab[i].exp);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rel_led", led_out, OFF);

        // Disabled: one-cycle registered pass-through
        prev = OFF;
        for (int i = 0; i < 5; i++) begin
            led_in = pt_tab[i].led_in;
            #1 chk($sformatf("pt_hold%0d", i), led_out, prev);
            @(negedge clk);
            chk($sformatf("pt%0d", i), led_out, pt_tab[i].exp_out);
            prev = pt_tab[i].exp_out;
        end

        // Register write/readback
        for (int i = 0; i < 8; i++) begin
            bus_write(reg_tab[i].wr_addr, reg_tab[i].wr_data);
            bus_read($sformatf("reg%0d", i), reg_tab[i].rd_addr, reg_tab[i].exp);
        end

        // PWM with duty shadowing; period_end lands on edges 512*k
        led_in = '0;
        wait_until(40);
        bus_write(REG_CTRL, 32'h0000_0100 | DUTY_A);
        wait_until(100);
        bus_read("duty_shadow", REG_STATUS, 32'h0000_FF03);
        wait_until(512);
        bus_read("duty_load", REG_STATUS, (DUTY_A << 8) | 32'h3);
        chk("pe_edge_led", led_out, 32'h0);
        check_win("pwm_on1",  513,  640,  32'h0);
        check_win("pwm_off1", 641,  1024, OFF);
        check_win("pwm_on2",  1025, 1152, 32'h0);
        check_win("pwm_off2", 1153, 1199, OFF);

        // Duty 0 then full scale
        bus_write(REG_CTRL, 32'h0000_0100);
        check_win("duty0", 1202, 1600, OFF);
        bus_read("duty0_status", REG_STATUS, 32'h0000_0002);
        led_in = PAT;
        bus_write(REG_CTRL, 32'h0000_01FF);
        check_win("dutyff_pend", 1603, 2048, OFF);
        check_win("dutyff",      2049, 2199, PAT);

        // Blink, period 2 PWM periods
        bus_write(REG_CTRL,  32'h0000_03FF);
        bus_write(REG_BLINK, 32'h0000_0002);
        check_win("blk_on1",  2203, 3072, PAT);
        check_win("blk_off1", 3073, 4096, OFF);
        check_win("blk_on2",  4097, 5120, PAT);
        check_win("blk_off2", 5121, 5299, OFF);
        bus_read("blk_status", REG_STATUS, 32'h0000_FF01);

        // Rewrite BLINK mid-period while blinked off: phase restarts on
        bus_write(REG_BLINK, 32'h0000_0002);
        check_win("rew_on",  5302, 6144, PAT);
        check_win("rew_off", 6145, 7168, OFF);
        check_win("rew_on2", 7169, 8190, PAT);

        // BLINK write on the period_end edge that would blink off
        bus_write(REG_BLINK, 32'h0000_0002);
        check_win("prio_on",  8193, 9216, PAT);
        check_win("prio_off", 9217, 9399, OFF);
        bus_write(REG_BLINK, 32'h0000_0000);
        check_win("hold_on",  9402, 9450, PAT);

        // Mid-period reset
        #2 reset = 1'b1;
        #1 chk("async_rst_led", led_out, OFF);
        @(negedge clk);
        for (int i = 0; i < 4; i++)
            bus_read($sformatf("rst2_rd%0d", i), rd_tab[i].addr, rd_tab[i].exp);
        reset = 1'b0;
        chk("rel2_led", led_out, OFF);
        @(negedge clk);
        chk("rst2_pt", led_out, PAT);

        // Timebase restarted from 0
        led_in = '0;
        wait_until(9);
        bus_write(REG_CTRL, 32'h0000_0100 | DUTY_A);
        check_win("re_pre",  11,  512, 32'h0);
        check_win("re_on",   513, 640, 32'h0);
        check_win("re_off",  641, 700, OFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
